conv_window_sequencer: RTL and testbench
========================================

Name: conv_window_sequencer

Overview:
- Parametrised successor to the fixed 32x32 / 3x3 address stage of the convolution pipeline.
- Walks every KxK filter window over an IMG_W x IMG_H image at a configurable stride, emitting one kernel row per beat: the image base address, the filter base address and accumulation flags.
- Beats leave on a valid/ready handshake so the downstream register/multiply/add stages can stall it.
- Start/busy/done control and a synchronous abort replace the free-running ring counter.

Parameters:
- IMG_W, 32: image width in pixels.
- IMG_H, 32: image height in pixels.
- K, 3: kernel size (KxK); K >= 1.
- STRIDE, 1: window step in both directions; STRIDE >= 1.
- AW, 10: image address width; must satisfy 2^AW >= IMG_W*IMG_H.
- FW, 4: filter address width; must satisfy 2^FW >= K*K.
- CW, 5: output-coordinate width; must hold OUT_W-1 and OUT_H-1.
- Derived values: OUT_W = (IMG_W-K)/STRIDE+1 and OUT_H = (IMG_H-K)/STRIDE+1, both floor division.

Ports:
- clk, in, 1: clock. Single clock domain; all logic is rising-edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle request to begin a frame; honoured only in IDLE.
- abort, in, 1: synchronous frame cancel.
- out_ready, in, 1: downstream accepts the current beat.
- out_valid, out, 1: beat valid.
- img_addr, out, AW: address of the leftmost pixel of the current kernel row, (orow*STRIDE+kr)*IMG_W + ocol*STRIDE.
- flt_addr, out, FW: filter base address, kr*K.
- kr, out, $clog2(K) (min 1): kernel row index.
- out_row, out, CW: output row index orow.
- out_col, out, CW: output column index ocol.
- first_tap, out, 1: kr==0; downstream clears its accumulator.
- last_tap, out, 1: kr==K-1; the window result is complete after this beat.
- end_sign, out, 1: last_tap of the final window (orow=OUT_H-1, ocol=OUT_W-1).
- busy, out, 1: high in RUN and DONE.
- done, out, 1: one-cycle pulse after the final beat transfers.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE.
- All outputs are registered; there is no combinational path from any input to any output.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start=1 and abort=0.
  - On that edge load kr=0, ocol=0, orow=0 and set out_valid=1.
  - The first beat appears the cycle after start (latency 1).
- RUN: a beat transfers on any cycle where out_valid & out_ready.
  - While not transferring, every output is held stable.
- Advance order on each transfer (kr fastest, orow slowest):
  - kr increments; when kr==K-1 it wraps to 0 and ocol increments.
  - When ocol==OUT_W-1 it wraps to 0 and orow increments.
- Address arithmetic: img_addr is recomputed from the next indices using adders and a registered row-base accumulator; no runtime multiplier.
  - Row base advances by IMG_W per kr step and by STRIDE*IMG_W per orow step.
  - Column offset advances by STRIDE.
- Final beat: a transfer with end_sign=1 takes RUN -> DONE.
  - out_valid goes to 0 on the same edge.
- DONE: done=1 for exactly one cycle, then IDLE. busy stays 1 during DONE.
- A frame is exactly OUT_H*OUT_W*K beats; with default parameters that is 30*30*3 = 2700.
- start while in RUN or DONE is ignored; it is not queued.
- abort in any state, at the next edge:
  - go to IDLE with out_valid=0 and done=0;
  - clear the indices.
  - Abort beats a simultaneous transfer and a simultaneous start.
- Asynchronous reset mid-frame behaves like abort, applied immediately.
- Parameter legality is checked at elaboration:
  - IMG_W >= K and IMG_H >= K;
  - AW, FW and CW are large enough.
  - Violation raises a fatal elaboration error.

Test Plan:
- Reset: hold rst_n=0 with start=1 and out_ready=1 -> all outputs stay 0 and the FSM stays in IDLE; releasing rst_n without a new start produces no beat.
- Defaults, out_ready tied high, start pulse:
  - Beats 1-4 -> img_addr 0/32/64/1 and kr 0/1/2/0; first_tap on beats 1 and 4; last_tap on beat 3.
  - Exactly 2700 back-to-back beats; final img_addr 1021 with end_sign=1.
  - done high exactly one cycle later, then busy=0.
- Backpressure:
  - Drive out_ready with a pseudo-random 40% duty -> outputs stay bit-stable across every stalled cycle.
  - The beat sequence is identical to the free-flowing run and still totals 2700 beats.
- IMG_W=IMG_H=8, K=3, STRIDE=2 -> OUT 3x3 and 27 beats.
  - Window (0,1) kr0: img_addr=2.
  - Window (1,0) kr0: img_addr=16.
  - Final beat: img_addr=(4+2)*8+4=52 with end_sign=1.
- Abort:
  - abort at beat 500 with out_ready=1 -> out_valid=0 next cycle, no done pulse, busy=0.
  - A following start restarts at img_addr 0, kr 0.
  - abort together with start in IDLE -> no frame starts.
- Start while busy:
  - start pulses in RUN and in the DONE cycle are ignored: beat count unchanged, a single done pulse.
  - A start one cycle after done begins a new frame.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// ---------------------------------------------------------------------------
// conv_window_sequencer
//
// Purpose:
//   Walks every KxK filter window over an IMG_W x IMG_H image at a fixed
//   stride and emits one kernel row per beat. Each beat carries the image
//   address of the leftmost pixel of that kernel row, the matching filter
//   base address and the accumulation flags for the downstream
//   register/multiply/add stages. Beats leave on a valid/ready handshake so
//   the consumer can stall the walk at any time.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   start_i      one-cycle frame request, honoured only when idle
//   abort_i      synchronous frame cancel, wins over start and transfers
//   out_ready_i  downstream accepts the current beat
//   out_valid_o  beat valid
//   img_addr_o   (orow*STRIDE+kr)*IMG_W + ocol*STRIDE
//   flt_addr_o   kr*K
//   kr_o         kernel row index
//   out_row_o    output row index
//   out_col_o    output column index
//   first_tap_o  kr==0, downstream clears its accumulator
//   last_tap_o   kr==K-1, window result complete after this beat
//   end_sign_o   last tap of the final window
//   busy_o       frame in progress or completing
//   done_o       one-cycle pulse after the final beat transfers
// ---------------------------------------------------------------------------
module conv_window_sequencer #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int AW     = 10,
  parameter int FW     = 4,
  parameter int CW     = 5
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   start_i,
  input  logic                                   abort_i,
  input  logic                                   out_ready_i,
  output logic                                   out_valid_o,
  output logic [AW-1:0]                          img_addr_o,
  output logic [FW-1:0]                          flt_addr_o,
  output logic [((K > 1) ? $clog2(K) : 1)-1:0]   kr_o,
  output logic [CW-1:0]                          out_row_o,
  output logic [CW-1:0]                          out_col_o,
  output logic                                   first_tap_o,
  output logic                                   last_tap_o,
  output logic                                   end_sign_o,
  output logic                                   busy_o,
  output logic                                   done_o
);

  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;

  // Reject geometries the counters and address registers cannot represent.
  if (K < 1 || STRIDE < 1) begin : g_bad_kernel
    $fatal(1, "conv_window_sequencer: K and STRIDE must be at least 1");
  end
  if (IMG_W < K || IMG_H < K) begin : g_bad_image
    $fatal(1, "conv_window_sequencer: image smaller than kernel");
  end
  if ((64'd1 << AW) < 64'(IMG_W) * 64'(IMG_H)) begin : g_bad_aw
    $fatal(1, "conv_window_sequencer: AW too small for IMG_W*IMG_H");
  end
  if ((64'd1 << FW) < 64'(K) * 64'(K)) begin : g_bad_fw
    $fatal(1, "conv_window_sequencer: FW too small for K*K");
  end
  if ((64'd1 << CW) < 64'(OUT_W) || (64'd1 << CW) < 64'(OUT_H)) begin : g_bad_cw
    $fatal(1, "conv_window_sequencer: CW too small for output coordinates");
  end

  localparam logic [KW-1:0] KR_MAX   = KW'(K - 1);
  localparam logic [CW-1:0] OCOL_MAX = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OROW_MAX = CW'(OUT_H - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
  localparam logic [AW-1:0] WIN_STEP = AW'(STRIDE * IMG_W);
  localparam logic [AW-1:0] COL_STEP = AW'(STRIDE);
  localparam logic [FW-1:0] FLT_STEP = FW'(K);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q;
  logic [KW-1:0] kr_q, kr_d;
  logic [CW-1:0] ocol_q, ocol_d;
  logic [CW-1:0] orow_q, orow_d;
  logic [AW-1:0] winBase_q, winBase_d;
  logic [AW-1:0] rowBase_q, rowBase_d;
  logic [AW-1:0] colOff_q, colOff_d;
  logic [FW-1:0] fltAddr_q, fltAddr_d;
  logic [AW-1:0] imgAddr_q;
  logic          valid_q, first_q, last_q, end_q, busy_q, done_q;
  logic          first_d, last_d, end_d;

  // Next indices for one beat transfer. winBase tracks the address of the
  // top row of the current window so a column step can rewind the row
  // base without a multiplier; an output-row step moves it down by
  // STRIDE image rows.
  always_comb begin
    kr_d      = kr_q;
    ocol_d    = ocol_q;
    orow_d    = orow_q;
    winBase_d = winBase_q;
    rowBase_d = rowBase_q;
    colOff_d  = colOff_q;
    fltAddr_d = fltAddr_q;
    if (kr_q != KR_MAX) begin
      kr_d      = kr_q + KW'(1);
      rowBase_d = rowBase_q + ROW_STEP;
      fltAddr_d = fltAddr_q + FLT_STEP;
    end else begin
      kr_d      = '0;
      fltAddr_d = '0;
      if (ocol_q != OCOL_MAX) begin
        ocol_d    = ocol_q + CW'(1);
        colOff_d  = colOff_q + COL_STEP;
        rowBase_d = winBase_q;
      end else begin
        ocol_d    = '0;
        colOff_d  = '0;
        orow_d    = orow_q + CW'(1);
        winBase_d = winBase_q + WIN_STEP;
        rowBase_d = winBase_q + WIN_STEP;
      end
    end
    first_d = (kr_d == '0);
    last_d  = (kr_d == KR_MAX);
    end_d   = last_d && (ocol_d == OCOL_MAX) && (orow_d == OROW_MAX);
  end

  // Control FSM with every output registered. Abort is checked ahead of
  // the state decode so it beats a simultaneous transfer or start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      kr_q      <= '0;
      ocol_q    <= '0;
      orow_q    <= '0;
      winBase_q <= '0;
      rowBase_q <= '0;
      colOff_q  <= '0;
      fltAddr_q <= '0;
      imgAddr_q <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (abort_i) begin
      state_q   <= IDLE;
      kr_q      <= '0;
      ocol_q    <= '0;
      orow_q    <= '0;
      winBase_q <= '0;
      rowBase_q <= '0;
      colOff_q  <= '0;
      fltAddr_q <= '0;
      imgAddr_q <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q   <= RUN;
            kr_q      <= '0;
            ocol_q    <= '0;
            orow_q    <= '0;
            winBase_q <= '0;
            rowBase_q <= '0;
            colOff_q  <= '0;
            fltAddr_q <= '0;
            imgAddr_q <= '0;
            valid_q   <= 1'b1;
            first_q   <= 1'b1;
            last_q    <= (K == 1);
            end_q     <= (K == 1) && (OUT_W == 1) && (OUT_H == 1);
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (valid_q && out_ready_i) begin
            if (end_q) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              kr_q      <= kr_d;
              ocol_q    <= ocol_d;
              orow_q    <= orow_d;
              winBase_q <= winBase_d;
              rowBase_q <= rowBase_d;
              colOff_q  <= colOff_d;
              fltAddr_q <= fltAddr_d;
              imgAddr_q <= rowBase_d + colOff_d;
              first_q   <= first_d;
              last_q    <= last_d;
              end_q     <= end_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o = valid_q;
  assign img_addr_o  = imgAddr_q;
  assign flt_addr_o  = fltAddr_q;
  assign kr_o        = kr_q;
  assign out_row_o   = orow_q;
  assign out_col_o   = ocol_q;
  assign first_tap_o = first_q;
  assign last_tap_o  = last_q;
  assign end_sign_o  = end_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_window_sequencer
//
// Directed bench for conv_window_sequencer. Instance A uses the default
// 32x32 / 3x3 / stride 1 geometry; instance B uses 8x8 / 3x3 / stride 2.
// Expected beats come from a closed-form model of the window walk.
// ---------------------------------------------------------------------------
module tb_conv_window_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  logic start, abort, outReady;
  logic startB, abortB, readyB;

  logic       outValidA, firstA, lastA, endA, busyA, doneA;
  logic [9:0] imgA;
  logic [3:0] fltA;
  logic [1:0] krA;
  logic [4:0] rowA, colA;

  logic       outValidB, firstB, lastB, endB, busyB, doneB;
  logic [9:0] imgB;
  logic [3:0] fltB;
  logic [1:0] krB;
  logic [4:0] rowB, colB;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  conv_window_sequencer dutA (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .out_ready_i (outReady),
    .out_valid_o (outValidA),
    .img_addr_o  (imgA),
    .flt_addr_o  (fltA),
    .kr_o        (krA),
    .out_row_o   (rowA),
    .out_col_o   (colA),
    .first_tap_o (firstA),
    .last_tap_o  (lastA),
    .end_sign_o  (endA),
    .busy_o      (busyA),
    .done_o      (doneA)
  );

  conv_window_sequencer #(.IMG_W(8), .IMG_H(8), .K(3), .STRIDE(2)) dutB (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (startB),
    .abort_i     (abortB),
    .out_ready_i (readyB),
    .out_valid_o (outValidB),
    .img_addr_o  (imgB),
    .flt_addr_o  (fltB),
    .kr_o        (krB),
    .out_row_o   (rowB),
    .out_col_o   (colB),
    .first_tap_o (firstB),
    .last_tap_o  (lastB),
    .end_sign_o  (endB),
    .busy_o      (busyB),
    .done_o      (doneB)
  );

  // Beat fields packed as {img, flt, kr, row, col, first, last, end}.
  function automatic logic [28:0] packA();
    return {imgA, fltA, krA, rowA, colA, firstA, lastA, endA};
  endfunction

  function automatic logic [28:0] packB();
    return {imgB, fltB, krB, rowB, colB, firstB, lastB, endB};
  endfunction

  // Closed-form expectation for beat n (0-based) of a K=3 frame.
  function automatic logic [28:0] modelBeat(input int n, input int imgW, input int outW,
                                            input int outH, input int stride);
    int         k, w, oc, orw, img;
    logic [9:0] imgV;
    logic [3:0] fltV;
    logic [1:0] krV;
    logic [4:0] rowV, colV;
    logic       fst, lst, fin;
    k    = n % 3;
    w    = n / 3;
    oc   = w % outW;
    orw  = w / outW;
    img  = (orw * stride + k) * imgW + oc * stride;
    imgV = 10'(img);
    fltV = 4'(k * 3);
    krV  = 2'(k);
    rowV = 5'(orw);
    colV = 5'(oc);
    fst  = (k == 0);
    lst  = (k == 2);
    fin  = lst && (oc == outW - 1) && (orw == outH - 1);
    return {imgV, fltV, krV, rowV, colV, fst, lst, fin};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r);
    start    = s;
    abort    = a;
    outReady = r;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives instance A through a frame whose first beat is already presented.
  // readyPct sets the out_ready duty; pokeStart pulses start at beat 100 and
  // in the DONE cycle; checkHead checks the first four beats against fixed
  // values.
  task automatic runFrame(input int readyPct, input bit pokeStart, input bit checkHead,
                          output int beats, output int dones);
    logic [28:0] snap;
    bit          stalled, finished, poked;
    int          headImg[4];
    int          headKr[4];
    headImg  = '{0, 32, 64, 1};
    headKr   = '{0, 1, 2, 0};
    beats    = 0;
    dones    = 0;
    stalled  = 1'b0;
    finished = 1'b0;
    poked    = 1'b0;
    snap     = '0;
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      if (stalled)
        checkOutput("stall_hold", 32'({outValidA, packA()}), 32'({1'b1, snap}));
      outReady = (readyPct >= 100) ? 1'b1 : ($urandom_range(0, 99) < readyPct);
      if (pokeStart && !poked && beats == 100) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (outValidA && outReady) begin
        checkOutput("beat", 32'(packA()), 32'(modelBeat(beats, 32, 30, 30, 1)));
        if (checkHead && beats < 4) begin
          checkOutput("head_img", 32'(imgA), 32'(headImg[beats]));
          checkOutput("head_kr", 32'(krA), 32'(headKr[beats]));
        end
        if (endA) begin
          checkOutput("final_img", 32'(imgA), 32'd1021);
          finished = 1'b1;
        end
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = outValidA;
        snap    = packA();
      end
      stepCycle();
    end
    start = 1'b0;
    checkOutput("frame_end_seen", 32'(finished), 32'd1);
    checkOutput("beat_count", 32'(beats), 32'd2700);
    checkOutput("done_cycle", 32'({doneA, busyA, outValidA}), 32'b110);
    if (doneA) dones++;
    start = pokeStart;
    stepCycle();
    start = 1'b0;
    if (doneA) dones++;
    checkOutput("after_done", 32'({doneA, busyA, outValidA}), 32'b000);
  endtask

  initial begin
    int  beats, dones, n;
    bit  finishedB;

    rst_n  = 1'b0;
    startB = 1'b0;
    abortB = 1'b0;
    readyB = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);

    // Reset held with start and ready asserted: everything stays at zero.
    repeat (3) stepCycle();
    checkOutput("reset_outputs", 32'({outValidA, busyA, doneA, packA()}), 32'd0);
    checkOutput("reset_outputs_b", 32'({outValidB, busyB, doneB, packB()}), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    repeat (3) begin
      stepCycle();
      checkOutput("no_beat_after_reset", 32'({outValidA, busyA}), 32'd0);
    end

    // Free-flowing frame.
    $display("[TB] free-flowing frame");
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("start_latency", 32'({outValidA, busyA}), 32'b11);
    runFrame(100, 1'b0, 1'b1, beats, dones);
    checkOutput("done_pulses_free", 32'(dones), 32'd1);

    // Same frame under random backpressure.
    $display("[TB] backpressure frame");
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    runFrame(40, 1'b0, 1'b0, beats, dones);
    checkOutput("done_pulses_bp", 32'(dones), 32'd1);

    // Abort while beat 500 is presented.
    $display("[TB] abort");
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (499) stepCycle();
    checkOutput("beat_500", 32'(packA()), 32'(modelBeat(499, 32, 30, 30, 1)));
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort_flags", 32'({outValidA, busyA, doneA}), 32'b000);
    checkOutput("abort_indices", 32'({imgA, krA, rowA, colA}), 32'd0);
    repeat (2) begin
      stepCycle();
      checkOutput("abort_no_done", 32'({outValidA, doneA}), 32'b00);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("restart_valid", 32'(outValidA), 32'd1);
    checkOutput("restart_beat", 32'(packA()), 32'(modelBeat(0, 32, 30, 30, 1)));
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort_with_start", 32'({outValidA, busyA}), 32'b00);
    stepCycle();
    checkOutput("abort_with_start_2", 32'({outValidA, busyA}), 32'b00);

    // Start pulses during RUN and DONE are ignored; a later start works.
    $display("[TB] start while busy");
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    runFrame(100, 1'b1, 1'b0, beats, dones);
    checkOutput("done_pulses_busy", 32'(dones), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("start_after_done", 32'({outValidA, imgA, krA}), 32'({1'b1, 10'd0, 2'd0}));
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);

    // 8x8 image, stride 2: 3x3 windows, 27 beats.
    $display("[TB] 8x8 stride 2 frame");
    startB = 1'b1;
    stepCycle();
    startB    = 1'b0;
    n         = 0;
    finishedB = 1'b0;
    for (int cyc = 0; cyc < 200 && !finishedB; cyc++) begin
      if (outValidB) begin
        checkOutput("b_beat", 32'(packB()), 32'(modelBeat(n, 8, 3, 3, 2)));
        if (n == 3) checkOutput("b_win01_img", 32'(imgB), 32'd2);
        if (n == 9) checkOutput("b_win10_img", 32'(imgB), 32'd16);
        if (endB) begin
          checkOutput("b_final_img", 32'(imgB), 32'd52);
          finishedB = 1'b1;
        end
        n++;
      end
      stepCycle();
    end
    checkOutput("b_beat_count", 32'(n), 32'd27);
    checkOutput("b_done", 32'({doneB, busyB, outValidB}), 32'b110);
    stepCycle();
    checkOutput("b_idle", 32'({doneB, busyB}), 32'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
